// File: rtl/apb_fab_timer_if.sv
// rtl/apb_fab_timer_if.sv - APB3 bus bundle between the MSS master and the fabric timer
//
// Purpose: groups the APB3 transfer signals so the timer and its master share one port.
// Signals:
//   PSEL, PENABLE, PWRITE   master -> slave  transfer control
//   PADDR[ADDR_W-1:0]       master -> slave  byte address
//   PWDATA[31:0]            master -> slave  write data
//   PRDATA[31:0]            slave -> master  read data
//   PREADY, PSLVERR         slave -> master  completion / error
interface apb_fab_timer_if #(
  parameter int ADDR_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fab_timer.sv
// rtl/apb_fab_timer.sv - APB3 prescaled 32-bit down-counter timer with level interrupt
//
// Purpose: fabric APB3 slave behind the MSS APB master. One-shot / periodic down counter
// advanced by a programmable prescaler, raising FABINT while an expiry is pending.
// Optional build macro: APB_FAB_TIMER_SLVERR_EN (PSLVERR on unmapped, VALUE-write and
// misaligned accesses; such transfers change nothing and return 0).
// Ports:
//   SYSCLK    in   fabric clock
//   SYSRESET  in   synchronous active-high reset
//   apb       slave modport of apb_fab_timer_if (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//             PRDATA/PREADY/PSLVERR out)
//   FABINT    out  registered level interrupt = pending & IRQ_EN
// Registers (PADDR[4:2]): 0 CTRL{IRQ_EN,PERIODIC,EN}, 1 LOAD, 2 VALUE (RO),
//   3 PRESCALE, 4 STATUS{pending, W1C}, 5-7 read 0.
module apb_fab_timer #(
  parameter int ADDR_W      = 8,
  parameter int PRESC_W     = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRESET,
  apb_fab_timer_if.slave        apb,
  output logic                  FABINT
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t             state;
  logic [1:0]         wcnt;
  logic               ready_q;
  logic [31:0]        rd_hold;
  logic [31:0]        rd_mux;

  logic [2:0]         ctrl;
  logic [31:0]        load;
  logic [31:0]        value;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] pcnt;
  logic               pending;

  logic [2:0]         idx;
  logic               err;
  logic               access;
  logic               wr;
  logic               rd_fire;
  logic               tick;
  logic               expire;
  logic               addr_unused;

  assign idx         = apb.PADDR[4:2];
  assign addr_unused = ^{apb.PADDR[ADDR_W-1:5], apb.PADDR[1:0]};

`ifdef APB_FAB_TIMER_SLVERR_EN
  assign err = (idx >= 3'd5) | (apb.PWRITE & (idx == 3'd2)) | (apb.PADDR[1:0] != 2'b00);
`else
  assign err = 1'b0;
`endif

  // The completing cycle is the one where PREADY is high inside an access phase.
  assign access  = ready_q & apb.PSEL & apb.PENABLE;
  assign wr      = access & apb.PWRITE & ~err;
  assign rd_fire = access & ~apb.PWRITE;

  assign apb.PREADY  = ready_q;
  assign apb.PSLVERR = access & err;
  // Live data in the completing cycle, then the captured copy until the next read.
  assign apb.PRDATA  = rd_fire ? rd_mux : rd_hold;

  always_comb begin
    rd_mux = 32'd0;
    if (!err) begin
      case (idx)
        3'd0:    rd_mux = {29'd0, ctrl};
        3'd1:    rd_mux = load;
        3'd2:    rd_mux = value;
        3'd3:    rd_mux = {{(32-PRESC_W){1'b0}}, prescale};
        3'd4:    rd_mux = {31'd0, pending};
        default: rd_mux = 32'd0;
      endcase
    end
  end

  // Wait-state handshake. The counter is loaded in the setup phase and counts the
  // PREADY-low access cycles; PREADY is registered so it rises as the count expires.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state   <= ST_IDLE;
      wcnt    <= 2'd0;
      ready_q <= 1'b0;
      rd_hold <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (apb.PSEL && !apb.PENABLE) begin
            wcnt <= 2'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state   <= ST_DONE;
              ready_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
          end else if (apb.PENABLE) begin
            if (wcnt <= 2'd1) begin
              wcnt    <= 2'd0;
              state   <= ST_DONE;
              ready_q <= 1'b1;
            end else begin
              wcnt <= wcnt - 2'd1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          if (rd_fire) rd_hold <= rd_mux;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign tick   = ctrl[0] & (pcnt == prescale);
  assign expire = tick & (value == 32'd0);

  // Register writes are ordered after the timer update so that a same-cycle
  // write wins for EN and VALUE, while an expiry beats a STATUS clear.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      ctrl     <= 3'd0;
      load     <= 32'd0;
      value    <= 32'd0;
      prescale <= '0;
      pcnt     <= '0;
      pending  <= 1'b0;
      FABINT   <= 1'b0;
    end else begin
      FABINT <= pending & ctrl[2];

      if (wr && idx == 3'd0)              ctrl    <= apb.PWDATA[2:0];
      else if (expire && !ctrl[1])        ctrl[0] <= 1'b0;

      if (wr && idx == 3'd1)              load     <= apb.PWDATA;
      if (wr && idx == 3'd3)              prescale <= apb.PWDATA[PRESC_W-1:0];

      if (wr && idx == 3'd1)              value <= apb.PWDATA;
      else if (tick) begin
        if (value != 32'd0)               value <= value - 32'd1;
        else if (ctrl[1])                 value <= load;
      end

      if (wr && idx == 3'd0 && !ctrl[0] && apb.PWDATA[0]) pcnt <= '0;
      else if (tick)                      pcnt <= '0;
      else if (ctrl[0])                   pcnt <= pcnt + PRESC_W'(1);

      if (expire)                         pending <= 1'b1;
      else if (wr && idx == 3'd4 && apb.PWDATA[0]) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_fab_timer.sv
// tb/tb_apb_fab_timer.sv - self-checking bench for apb_fab_timer against a behavioural model
module tb_apb_fab_timer;
  localparam int ADDR_W  = 8;
  localparam int PRESC_W = 16;
  localparam int WS      = 1;

  logic SYSCLK = 1'b0;
  logic SYSRESET;
  logic FABINT;

  apb_fab_timer_if #(.ADDR_W(ADDR_W)) bus();

  apb_fab_timer #(.ADDR_W(ADDR_W), .PRESC_W(PRESC_W), .WAIT_STATES(WS)) dut (
    .SYSCLK  (SYSCLK),
    .SYSRESET(SYSRESET),
    .apb     (bus),
    .FABINT  (FABINT)
  );

  always #5 SYSCLK = ~SYSCLK;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: what the registers should hold after each clock.
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_value;
  logic [15:0] m_presc, m_pcnt;
  logic        m_pend, m_fab;
  // Transfer the bench expects to complete in the current cycle.
  logic        c_en = 1'b0;
  logic        c_wr;
  logic [7:0]  c_addr;
  logic [31:0] c_data;

  function automatic logic is_err(input logic w, input logic [7:0] a);
`ifdef APB_FAB_TIMER_SLVERR_EN
    return (a[4:2] >= 3'd5) || (w && a[4:2] == 3'd2) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a[4:2])
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_load;
      3'd2:    return m_value;
      3'd3:    return {16'd0, m_presc};
      3'd4:    return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  logic [2:0]  n_ctrl;
  logic [31:0] n_load, n_value;
  logic [15:0] n_presc, n_pcnt;
  logic        n_pend, was_en, fired;

  always @(posedge SYSCLK) begin
    if (SYSRESET) begin
      m_ctrl <= 0; m_load <= 0; m_value <= 0; m_presc <= 0;
      m_pcnt <= 0; m_pend <= 0; m_fab <= 0;
    end else begin
      n_ctrl = m_ctrl; n_load = m_load; n_value = m_value;
      n_presc = m_presc; n_pcnt = m_pcnt; n_pend = m_pend;
      was_en = m_ctrl[0];
      fired  = 1'b0;
      if (m_ctrl[0] && m_pcnt == m_presc) begin
        n_pcnt = 0;
        if (m_value == 0) begin
          fired  = 1'b1;
          n_pend = 1'b1;
          if (m_ctrl[1]) n_value = m_load;
          else           n_ctrl[0] = 1'b0;
        end else begin
          n_value = m_value - 1;
        end
      end else if (m_ctrl[0]) begin
        n_pcnt = m_pcnt + 1;
      end
      if (c_en && c_wr && !is_err(1'b1, c_addr)) begin
        case (c_addr[4:2])
          3'd0: begin
            if (!was_en && c_data[0]) n_pcnt = 0;
            n_ctrl = c_data[2:0];
          end
          3'd1: begin n_load = c_data; n_value = c_data; end
          3'd3: n_presc = c_data[15:0];
          3'd4: if (c_data[0] && !fired) n_pend = 1'b0;
          default: ;
        endcase
      end
      m_fab   <= m_pend & m_ctrl[2];
      m_ctrl  <= n_ctrl;  m_load <= n_load; m_value <= n_value;
      m_presc <= n_presc; m_pcnt <= n_pcnt; m_pend  <= n_pend;
    end
  end

  // One APB transfer; returns right after its PREADY cycle so calls chain back-to-back.
  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input string name, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    @(negedge SYSCLK);
    c_en = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    vectors++;
    if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL %s setup_pready: got %b want 0", name, bus.PREADY); end
    @(negedge SYSCLK);
    bus.PENABLE = 1'b1;
    for (int i = 0; i < WS; i++) begin
      vectors++;
      if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL %s wait_pready[%0d]: got %b want 0", name, i, bus.PREADY); end
      @(negedge SYSCLK);
    end
    exp_err = is_err(w, a);
    exp_rd  = exp_err ? 32'd0 : m_read(a);
    vectors++;
    if (bus.PREADY !== 1'b1) begin errors++; $display("FAIL %s done_pready: got %b want 1", name, bus.PREADY); end
    vectors++;
    if (bus.PSLVERR !== exp_err) begin errors++; $display("FAIL %s pslverr: got %b want %b", name, bus.PSLVERR, exp_err); end
    if (!w) begin
      vectors++;
      if (bus.PRDATA !== exp_rd) begin errors++; $display("FAIL %s prdata: got %h want %h", name, bus.PRDATA, exp_rd); end
    end
    vectors++;
    if (FABINT !== m_fab) begin errors++; $display("FAIL %s fabint: got %b want %b", name, FABINT, m_fab); end
    rd = bus.PRDATA;
    c_en = 1'b1; c_wr = w; c_addr = a; c_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SYSCLK);
      c_en = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      vectors++;
      if (FABINT !== m_fab) begin errors++; $display("FAIL idle_fabint: got %b want %b", FABINT, m_fab); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    SYSRESET = 1'b1;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    repeat (3) @(negedge SYSCLK);
    SYSRESET = 1'b0;
    vectors++;
    if ({bus.PREADY, bus.PSLVERR, FABINT} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b want 000", {bus.PREADY, bus.PSLVERR, FABINT});
    end
    vectors++;
    if (bus.PRDATA !== 32'd0) begin errors++; $display("FAIL reset_prdata: got %h want 0", bus.PRDATA); end
    apb(0, 8'h00, 0, "reset_ctrl_rd", rd);
    idle(1);
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    apb(1, 8'h04, 3, "os_load", rd);
    apb(1, 8'h0C, 0, "os_presc", rd);
    apb(1, 8'h00, 5, "os_ctrl", rd);
    idle(8);
    apb(0, 8'h08, 0, "os_value", rd);
    apb(0, 8'h00, 0, "os_ctrl_rd", rd);
    vectors++;
    if (rd[0] !== 1'b0) begin errors++; $display("FAIL os_en_cleared: got %b want 0", rd[0]); end
    apb(0, 8'h10, 0, "os_status", rd);
    vectors++;
    if (rd !== 32'd1) begin errors++; $display("FAIL os_pending: got %h want 1", rd); end
    vectors++;
    if (FABINT !== 1'b1) begin errors++; $display("FAIL os_fabint: got %b want 1", FABINT); end
    apb(1, 8'h10, 1, "os_w1c", rd);
    idle(3);
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    apb(1, 8'h04, 2, "per_load", rd);
    apb(1, 8'h0C, 1, "per_presc", rd);
    apb(1, 8'h00, 7, "per_ctrl", rd);
    for (int i = 0; i < 6; i++) begin
      apb(0, 8'h08, 0, "per_value", rd);
      idle(i % 3);
    end
    apb(1, 8'h10, 1, "per_w1c", rd);
    idle(14);
    apb(1, 8'h00, 0, "per_stop", rd);
    apb(1, 8'h10, 1, "per_clr", rd);
    idle(2);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd;
    apb(1, 8'h04, 0, "col_load", rd);
    apb(1, 8'h0C, 0, "col_presc", rd);
    apb(1, 8'h00, 7, "col_ctrl", rd);
    idle(2);
    apb(1, 8'h10, 1, "col_w1c", rd);
    idle(2);
    vectors++;
    if (FABINT !== 1'b1) begin errors++; $display("FAIL col_fabint: got %b want 1", FABINT); end
    apb(0, 8'h10, 0, "col_status", rd);
    vectors++;
    if (rd !== 32'd1) begin errors++; $display("FAIL col_pending: got %h want 1", rd); end
    apb(1, 8'h00, 0, "col_stop", rd);
    apb(1, 8'h10, 1, "col_clr", rd);
    apb(0, 8'h10, 0, "col_cleared", rd);
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    @(negedge SYSCLK);
    c_en = 1'b0;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 8'h04; bus.PWDATA = 32'hFFFF;
    @(negedge SYSCLK);
    bus.PENABLE = 1;
    vectors++;
    if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL mid_wait_pready: got %b want 0", bus.PREADY); end
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    SYSRESET = 1'b0; bus.PSEL = 0; bus.PENABLE = 0;
    vectors++;
    if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL mid_after_pready: got %b want 0", bus.PREADY); end
    idle(1);
    apb(0, 8'h04, 0, "mid_load_rd", rd);
    vectors++;
    if (rd !== 32'd0) begin errors++; $display("FAIL mid_no_commit: got %h want 0", rd); end
    apb(1, 8'h04, 32'h5A, "mid_load_wr", rd);
    apb(0, 8'h04, 0, "mid_load_rd2", rd);
    vectors++;
    if (rd !== 32'h5A) begin errors++; $display("FAIL mid_next_ok: got %h want 5a", rd); end
    idle(1);
  endtask

  task automatic test_slverr();
    logic [31:0] rd;
    apb(0, 8'h18, 0, "err_rd18", rd);
    apb(1, 8'h08, 32'h1234, "err_wr08", rd);
    apb(0, 8'h08, 0, "err_value", rd);
    apb(1, 8'h06, 32'h77, "err_mis", rd);
    apb(0, 8'h04, 0, "err_load", rd);
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    apb(1, 8'h0C, 2, "b2b_presc", rd);
    apb(0, 8'h0C, 0, "b2b_presc_rd", rd);
    apb(1, 8'h04, 4, "b2b_load", rd);
    apb(1, 8'h00, 3, "b2b_ctrl", rd);
    apb(0, 8'h08, 0, "b2b_val", rd);
    apb(0, 8'h08, 0, "b2b_val2", rd);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    logic [7:0]  a;
    logic        w;
    for (int i = 0; i < 60; i++) begin
      a = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (a[4:2] == 3'd0) d = 32'($urandom_range(0, 7));
      apb(w, a, d, "rand", rd);
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_w1c_collision();
    test_reset_mid();
    test_slverr();
    test_back_to_back();
    test_random();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
